sc_fir_engine: RTL and testbench

- Parametrised stochastic-computing FIR engine; next generation of the fixed 4-tap, 8-bit binary-converter front end.
- Accepts one binary sample per handshake and shifts it into a TAPS-deep delay line.
- Runs one 2^N-cycle stochastic window using SNG comparators, per-tap multiply, and MUX scaled addition, then returns the ones-count as a binary result.
- Sits between the sample source and the binary FIR output stage.

---
 rtl/sc_fir_pkg.sv | 34 +++
 rtl/sc_fir_engine_rng.sv | 42 ++++
 rtl/sc_fir_engine.sv | 142 ++++++++++++++
 tb/tb_sc_fir_engine.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_fir_pkg.sv
// Shared types and constants for the stochastic-computing FIR engine.
package sc_fir_pkg;

   localparam int unsigned N_DEF    = 32'd8;
   localparam int unsigned TAPS_DEF = 32'd4;
   localparam int unsigned W_DEF    = N_DEF + 32'd1;
   localparam int unsigned SEL_W_DEF = $clog2(TAPS_DEF);

   localparam logic [7:0] SEED_X_DEF = 8'h5A;
   localparam logic [7:0] SEED_C_DEF = 8'hC3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Maximal-length Fibonacci feedback masks (bit t-1 set for tap t), N = 4..12.
   function automatic logic [11:0] lfsr_taps(input int unsigned n);
      case (n)
         32'd4:   lfsr_taps = 12'h00C;
         32'd5:   lfsr_taps = 12'h014;
         32'd6:   lfsr_taps = 12'h030;
         32'd7:   lfsr_taps = 12'h060;
         32'd8:   lfsr_taps = 12'h0B8;
         32'd9:   lfsr_taps = 12'h110;
         32'd10:  lfsr_taps = 12'h240;
         32'd11:  lfsr_taps = 12'h500;
         32'd12:  lfsr_taps = 12'h829;
         default: lfsr_taps = 12'h000;
      endcase
   endfunction

endpackage

// File: rtl/sc_fir_engine_rng.sv
// N-bit LFSR random source with zero-state insertion: each 2^N-step period
// visits every value 0..2^N-1 exactly once.
module sc_rng
   import sc_fir_pkg::*;
#(
   parameter int unsigned  N    = N_DEF,
   parameter logic [N-1:0] SEED = {{(N-1){1'b0}}, 1'b1}
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         en,
   output logic [N-1:0] r
);

   localparam logic [11:0]  TAP_ALL = lfsr_taps(N);
   localparam logic [N-1:0] MASK    = TAP_ALL[N-1:0];

   logic [N-1:0] state_q;
   logic [N-1:0] state_d;
   logic         fb_s;

   // The all-zero low-bits term diverts 100..0 -> 0 -> 00..01, splicing zero into the cycle.
   always_comb begin
      fb_s = (^(state_q & MASK)) ^ (state_q[N-2:0] == {(N-1){1'b0}});
      if (en) begin
         state_d = {state_q[N-2:0], fb_s};
      end else begin
         state_d = state_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign r = state_q;

endmodule

// File: rtl/sc_fir_engine.sv
// Stochastic FIR engine: one sample per handshake, one 2^N-cycle bitstream
// window of SNG compare, per-tap multiply and MUX-scaled addition per sample.
module sc_fir_engine
   import sc_fir_pkg::*;
#(
   parameter int unsigned N       = N_DEF,
   parameter int unsigned TAPS    = TAPS_DEF,
   parameter bit          BIPOLAR = 1'b0,
   parameter logic [7:0]  SEED_X  = SEED_X_DEF,
   parameter logic [7:0]  SEED_C  = SEED_C_DEF
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic [N:0]            in,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [TAPS*(N+1)-1:0] coef,
   output logic [N:0]            out,
   output logic                  out_valid
);

   localparam int unsigned W     = N + 32'd1;
   localparam int unsigned SEL_W = $clog2(TAPS);

   state_e                   state_q, state_d;
   logic [TAPS-1:0][W-1:0]   dl_q, dl_d;
   logic [TAPS-1:0][W-1:0]   coef_q, coef_d;
   logic [N-1:0]             win_q, win_d;
   logic [W-1:0]             cnt_q, cnt_d;
   logic [W-1:0]             out_q, out_d;
   logic                     in_ready_q, in_ready_d;
   logic                     out_valid_q, out_valid_d;

   logic [N-1:0]             r_x_s, r_c_s;
   logic [TAPS-1:0]          x_s, c_s, p_s;
   logic                     run_s, accept_s;

   assign run_s    = (state_q == RUN);
   assign accept_s = (state_q == IDLE) && in_valid && in_ready_q;

   sc_rng #(.N(N), .SEED(N'(SEED_X))) u_rng_x (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (run_s),
      .r       (r_x_s)
   );

   sc_rng #(.N(N), .SEED(N'(SEED_C))) u_rng_c (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (run_s),
      .r       (r_c_s)
   );

   // Per-tap stochastic number generation and multiply.
   always_comb begin
      for (int k = 0; k < TAPS; k++) begin
         x_s[k] = dl_q[k] > {1'b0, r_x_s};
         c_s[k] = coef_q[k] > {1'b0, r_c_s};
         if (BIPOLAR) begin
            p_s[k] = ~(x_s[k] ^ c_s[k]);
         end else begin
            p_s[k] = x_s[k] & c_s[k];
         end
      end
   end

   // Window sequencing; clear is applied before the accepted sample shifts in.
   always_comb begin
      state_d     = state_q;
      dl_d        = dl_q;
      coef_d      = coef_q;
      win_d       = win_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (clear) begin
               dl_d = {(TAPS*W){1'b0}};
            end else begin
               dl_d = dl_q;
            end
            if (accept_s) begin
               dl_d    = {dl_d[TAPS-2:0], in};
               coef_d  = coef;
               win_d   = {N{1'b0}};
               cnt_d   = {W{1'b0}};
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            cnt_d = cnt_q + {{N{1'b0}}, p_s[win_q[SEL_W-1:0]]};
            win_d = win_q + {{(N-1){1'b0}}, 1'b1};
            if (win_q == {N{1'b1}}) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
         end
         DONE: begin
            out_d       = cnt_q;
            out_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      in_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         dl_q        <= {(TAPS*W){1'b0}};
         coef_q      <= {(TAPS*W){1'b0}};
         win_q       <= {N{1'b0}};
         cnt_q       <= {W{1'b0}};
         out_q       <= {W{1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         dl_q        <= dl_d;
         coef_q      <= coef_d;
         win_q       <= win_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out       = out_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sc_fir_engine.sv
// Randomised self-checking bench for sc_fir_engine: unipolar and bipolar
// N=8/TAPS=4 engines driven in lockstep, plus an N=4/TAPS=8 sweep engine.
module tb_sc_fir_engine;

   logic        clock;
   logic        reset_n;

   logic        clear_ab, in_valid_ab;
   logic [8:0]  in_ab;
   logic [35:0] coef_ab;
   logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
   logic [8:0]  out_a, out_b;

   logic        clear_c, in_valid_c;
   logic [4:0]  in_c;
   logic [39:0] coef_c;
   logic        in_ready_c, out_valid_c;
   logic [4:0]  out_c;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference state: cfg 0 = N8/TAPS4, cfg 1 = N4/TAPS8.
   int smp [2][16];
   int cf  [2][16];
   int sx  [2][256];
   int sc  [2][256];

   sc_fir_engine #(.N(8), .TAPS(4), .BIPOLAR(1'b0)) u_dut_a (
      .clock(clock), .reset_n(reset_n), .clear(clear_ab), .in(in_ab),
      .in_valid(in_valid_ab), .in_ready(in_ready_a), .coef(coef_ab),
      .out(out_a), .out_valid(out_valid_a));

   sc_fir_engine #(.N(8), .TAPS(4), .BIPOLAR(1'b1)) u_dut_b (
      .clock(clock), .reset_n(reset_n), .clear(clear_ab), .in(in_ab),
      .in_valid(in_valid_ab), .in_ready(in_ready_b), .coef(coef_ab),
      .out(out_b), .out_valid(out_valid_b));

   sc_fir_engine #(.N(4), .TAPS(8), .BIPOLAR(1'b0)) u_dut_c (
      .clock(clock), .reset_n(reset_n), .clear(clear_c), .in(in_c),
      .in_valid(in_valid_c), .in_ready(in_ready_c), .coef(coef_c),
      .out(out_c), .out_valid(out_valid_c));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int got, input int want);
      n_checks++;
      if (got == want) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   // Sequence visited by a maximal LFSR with the zero state spliced in after 100..0.
   function automatic int lfsr_next(input int s, input int n, input int mask);
      if (s == (1 << (n - 1))) return 0;
      if (s == 0) return 1;
      return ((s << 1) & ((1 << n) - 1)) | ($countones(s & mask) & 1);
   endfunction

   // Ones-count of one window: cycle t uses tap t mod TAPS and the t-th random pair.
   function automatic int ref_count(input int cfg, input bit bip);
      int n, taps, cnt, k;
      bit x, c;
      n = (cfg == 0) ? 8 : 4;
      taps = (cfg == 0) ? 4 : 8;
      cnt = 0;
      for (int t = 0; t < (1 << n); t++) begin
         k = t % taps;
         x = smp[cfg][k] > sx[cfg][t];
         c = cf[cfg][k] > sc[cfg][t];
         if (bip ? (x == c) : (x && c)) cnt++;
      end
      return cnt;
   endfunction

   task automatic run_win(input int cfg, input int s, input bit clr, input bit hold,
                          input string tag);
      int n, lat, rdy_low, held;
      bit ov;
      n = (cfg == 0) ? 8 : 4;
      @(negedge clock);
      check({tag, "_rdy"}, (cfg == 0) ? in_ready_a : in_ready_c, 1);
      if (cfg == 0) begin
         in_ab = 9'(s);
         clear_ab = clr;
         in_valid_ab = 1'b1;
         for (int k = 0; k < 4; k++) coef_ab[k*9 +: 9] = 9'(cf[0][k]);
      end else begin
         in_c = 5'(s);
         clear_c = clr;
         in_valid_c = 1'b1;
         for (int k = 0; k < 8; k++) coef_c[k*5 +: 5] = 5'(cf[1][k]);
      end
      if (clr) for (int k = 0; k < 16; k++) smp[cfg][k] = 0;
      for (int k = 15; k > 0; k--) smp[cfg][k] = smp[cfg][k-1];
      smp[cfg][0] = s;
      @(negedge clock);
      clear_ab = 1'b0;
      clear_c = 1'b0;
      if (!hold) begin
         in_valid_ab = 1'b0;
         in_valid_c = 1'b0;
      end
      lat = 0;
      rdy_low = 0;
      ov = (cfg == 0) ? out_valid_a : out_valid_c;
      while (!ov && lat < (1 << n) + 8) begin
         if (((cfg == 0) ? in_ready_a : in_ready_c) == 1'b0) rdy_low++;
         @(negedge clock);
         lat++;
         ov = (cfg == 0) ? out_valid_a : out_valid_c;
      end
      in_valid_ab = 1'b0;
      in_valid_c = 1'b0;
      check({tag, "_lat"}, lat, (1 << n) + 1);
      check({tag, "_rdylow"}, rdy_low, (1 << n) + 1);
      if (cfg == 0) begin
         check({tag, "_uni"}, int'(out_a), ref_count(0, 1'b0));
         check({tag, "_bip"}, int'(out_b), ref_count(0, 1'b1));
         held = int'(out_a);
      end else begin
         check({tag, "_c"}, int'(out_c), ref_count(1, 1'b0));
         held = int'(out_c);
      end
      @(negedge clock);
      check({tag, "_pulse"}, (cfg == 0) ? out_valid_a : out_valid_c, 0);
      check({tag, "_hold"}, (cfg == 0) ? int'(out_a) : int'(out_c), held);
   endtask

   initial begin
      int pulses, s;
      real ideal, err_sum, mean;

      sx[0][0] = 'h5A; sc[0][0] = 'hC3;
      sx[1][0] = 'hA;  sc[1][0] = 'h3;
      for (int t = 0; t < 255; t++) begin
         sx[0][t+1] = lfsr_next(sx[0][t], 8, 'hB8);
         sc[0][t+1] = lfsr_next(sc[0][t], 8, 'hB8);
      end
      for (int t = 0; t < 15; t++) begin
         sx[1][t+1] = lfsr_next(sx[1][t], 4, 'hC);
         sc[1][t+1] = lfsr_next(sc[1][t], 4, 'hC);
      end
      for (int c = 0; c < 2; c++) for (int k = 0; k < 16; k++) begin
         smp[c][k] = 0;
         cf[c][k] = 0;
      end

      reset_n = 1'b0;
      clear_ab = 1'b0; in_valid_ab = 1'b0; in_ab = '0; coef_ab = '0;
      clear_c = 1'b0;  in_valid_c = 1'b0;  in_c = '0;  coef_c = '0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("rst_rdy_a", in_ready_a, 1);
      check("rst_rdy_b", in_ready_b, 1);
      check("rst_rdy_c", in_ready_c, 1);
      check("rst_out_a", out_a, 0);
      check("rst_ov_a", out_valid_a, 0);
      check("rst_ov_b", out_valid_b, 0);
      check("rst_ov_c", out_valid_c, 0);

      // Full-scale samples and coefficients.
      for (int k = 0; k < 4; k++) cf[0][k] = 256;
      for (int i = 0; i < 4; i++) run_win(0, 256, i == 0, 1'b0, "full");
      check("full_out256", out_a, 256);

      for (int i = 0; i < 4; i++) run_win(0, 0, i == 0, 1'b0, "zero_x");
      check("zero_x_out0", out_a, 0);

      for (int k = 0; k < 4; k++) cf[0][k] = 0;
      for (int i = 0; i < 4; i++) run_win(0, 256, i == 0, 1'b0, "zero_c");
      check("zero_c_uni0", out_a, 0);
      check("zero_c_bip0", out_b, 0);

      for (int i = 0; i < 4; i++) run_win(0, 0, 1'b0, 1'b0, "bip_ones");
      check("bip_ones_256", out_b, 256);

      // Single contributing tap: the 128 sample ends up in tap3.
      cf[0][3] = 256;
      run_win(0, 128, 1'b1, 1'b0, "tap3");
      for (int i = 0; i < 3; i++) run_win(0, 0, 1'b0, 1'b0, "tap3");

      cf[0][0] = 200; cf[0][1] = 100; cf[0][2] = 50; cf[0][3] = 256;
      run_win(0, 77, 1'b0, 1'b1, "hold");
      run_win(0, 33, 1'b0, 1'b0, "after_hold");

      // Abort a window with reset.
      for (int k = 0; k < 4; k++) cf[0][k] = 256;
      @(negedge clock);
      in_ab = 9'd256; in_valid_ab = 1'b1;
      for (int k = 0; k < 4; k++) coef_ab[k*9 +: 9] = 9'd256;
      @(negedge clock);
      in_valid_ab = 1'b0;
      repeat (100) @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("async_rst_rdy", in_ready_a, 1);
      check("async_rst_out", out_a, 0);
      @(negedge clock);
      reset_n = 1'b1;
      for (int c = 0; c < 2; c++) for (int k = 0; k < 16; k++) smp[c][k] = 0;
      pulses = 0;
      repeat (300) begin
         @(negedge clock);
         if (out_valid_a) pulses++;
      end
      check("abort_no_ov", pulses, 0);
      for (int k = 0; k < 4; k++) cf[0][k] = 0;
      run_win(0, 0, 1'b0, 1'b0, "post_rst_zero");
      check("post_rst_dl0", out_b, 256);
      cf[0][0] = 256; cf[0][1] = 128; cf[0][2] = 64; cf[0][3] = 200;
      run_win(0, 200, 1'b0, 1'b0, "post_rst_fresh");

      // Random sweep on the N=4, TAPS=8 engine.
      err_sum = 0.0;
      for (int w = 0; w < 200; w++) begin
         for (int k = 0; k < 8; k++) cf[1][k] = $urandom_range(0, 16);
         s = $urandom_range(0, 16);
         run_win(1, s, w == 0, 1'b0, "sweep");
         ideal = 0.0;
         for (int k = 0; k < 8; k++) ideal += real'(smp[1][k] * cf[1][k]);
         ideal = ideal / 128.0;
         err_sum += real'(out_c) - ideal;
      end
      mean = err_sum / 200.0;
      check("sweep_mean_err", (mean < 2.0 && mean > -2.0) ? 1 : 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
